// File: rtl/instr_mem_responder.sv
// instr_mem_responder: fixed-latency instruction memory responder with backdoor program load.
// Optional feature: define INSTR_MEM_RESP_STALL_EN to add LFSR-driven pseudo-random grant stalls.
module instr_mem_responder #(
   parameter logic [31:0] MEM_BASE  = 32'h0000_0000,
   parameter int          MEM_WORDS = 1024,
   parameter int          LATENCY   = 2
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        instr_req_i,
   input  logic [31:0] instr_addr_i,
   output logic        instr_gnt_o,
   output logic        instr_rvalid_o,
   output logic [31:0] instr_rdata_o,
   output logic        instr_err_o,
   input  logic        load_we_i,
   input  logic [31:0] load_addr_i,
   input  logic [31:0] load_wdata_i
);
   localparam int          IW   = $clog2(MEM_WORDS);
   localparam logic [31:0] SPAN = 32'(4 * MEM_WORDS);

   logic [31:0]        mem [MEM_WORDS];
   logic [31:0]        fetch_off, load_off;
   logic               fetch_ok, load_ok, stall;
   logic [LATENCY-1:0] pipe_valid, pipe_err;
   logic [31:0]        pipe_data [LATENCY];

   assign fetch_off = instr_addr_i - MEM_BASE;
   assign load_off  = load_addr_i - MEM_BASE;
   assign fetch_ok  = fetch_off < SPAN && instr_addr_i[1:0] == 2'b00;
   assign load_ok   = load_off < SPAN && load_addr_i[1:0] == 2'b00;

`ifdef INSTR_MEM_RESP_STALL_EN
   logic [7:0] lfsr;

   // Fibonacci LFSR (taps 8,6,5,4) free-running every cycle; bit 0 vetoes the grant
   always_ff @(posedge clk_i or posedge rst_i)
      if (rst_i) lfsr <= 8'hA5;
      else       lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};

   assign stall = lfsr[0];
`else
   assign stall = 1'b0;
`endif

   assign instr_gnt_o = instr_req_i & ~rst_i & ~stall;

   // Backdoor load: memory is never reset, out-of-range or misaligned writes are dropped
   always_ff @(posedge clk_i)
      if (load_we_i && load_ok) mem[load_off[IW+1:2]] <= load_wdata_i;

   // Response shift pipeline; stage 0 reads memory before any same-edge load write lands
   always_ff @(posedge clk_i or posedge rst_i)
      if (rst_i) begin
         pipe_valid <= '0;
         pipe_err   <= '0;
         for (int i = 0; i < LATENCY; i++) pipe_data[i] <= '0;
      end else begin
         pipe_valid[0] <= instr_gnt_o;
         pipe_err[0]   <= instr_gnt_o & ~fetch_ok;
         pipe_data[0]  <= (instr_gnt_o && fetch_ok) ? mem[fetch_off[IW+1:2]] : 32'h0;
         for (int i = 1; i < LATENCY; i++) begin
            pipe_valid[i] <= pipe_valid[i-1];
            pipe_err[i]   <= pipe_err[i-1];
            pipe_data[i]  <= pipe_data[i-1];
         end
      end

   assign instr_rvalid_o = pipe_valid[LATENCY-1];
   assign instr_err_o    = pipe_err[LATENCY-1];
   assign instr_rdata_o  = pipe_data[LATENCY-1];
endmodule

// File: doc/instr_mem_responder.md
INSTR_MEM_RESPONDER -- requirements
Module: instr_mem_responder

Interface
REQ-001 SHALL have parameter MEM_BASE, default 32'h00000000, byte address of word 0.
REQ-002 SHALL have parameter MEM_WORDS, default 1024, number of 32-bit words (power of two, 16..65536).
REQ-003 SHALL have parameter LATENCY, default 2, cycles from grant to rvalid (legal 1..4).
REQ-004 SHALL have port clk_i, input, 1, sole clock, rising edge.
REQ-005 SHALL have port rst_i, input, 1, reset: asynchronous, active-high.
REQ-006 SHALL have port instr_req_i, input, 1, fetch request from the initiator.
REQ-007 SHALL have port instr_addr_i, input, 32, byte fetch address.
REQ-008 SHALL have port instr_gnt_o, output, 1, request accepted this cycle.
REQ-009 SHALL have port instr_rvalid_o, output, 1, response valid.
REQ-010 SHALL have port instr_rdata_o, output, 32, response data.
REQ-011 SHALL have port instr_err_o, output, 1, response error, qualified by rvalid.
REQ-012 SHALL have port load_we_i, input, 1, backdoor program-load write enable.
REQ-013 SHALL have port load_addr_i, input, 32, byte address of load write.
REQ-014 SHALL have port load_wdata_i, input, 32, load write data.

Function
REQ-015 SHALL treat a request as accepted in every cycle where instr_req_i and instr_gnt_o are both 1; instr_gnt_o combinational from instr_req_i and stall state.
REQ-016 SHALL assert instr_gnt_o = instr_req_i when no stall is active; sustained throughput one accept per cycle.
REQ-017 SHALL assert instr_rvalid_o for exactly one cycle, exactly LATENCY cycles after each accept cycle; responses strictly in accept order.
REQ-018 SHALL implement a LATENCY-deep shift pipeline of {valid, err, data}; up to LATENCY responses in flight, no backpressure from initiator.
REQ-019 SHALL compute offset = instr_addr_i - MEM_BASE modulo 2^32; request valid iff offset < 4*MEM_WORDS and instr_addr_i[1:0] == 2'b00.
REQ-020 SHALL, for a valid request, return the word at index offset[31:2] as sampled in the accept cycle, with instr_err_o = 0.
REQ-021 SHALL, for an invalid request (below MEM_BASE, at/after end, misaligned), still grant and respond at LATENCY with instr_err_o = 1, instr_rdata_o = 32'h0.
REQ-022 SHALL drive instr_rdata_o = 32'h0 and instr_err_o = 0 whenever instr_rvalid_o = 0.
REQ-023 SHALL write load_wdata_i to memory at the clock edge when load_we_i = 1 and load address is valid per REQ-019; invalid load writes are silently dropped.
REQ-024 SHALL use read-before-write on collision: a fetch accepted in the same cycle as a load write to the same word returns the old contents.
REQ-025 SHALL leave memory contents uninitialised by reset; only control state resets.

Reset
REQ-026 SHALL, on rst_i high, asynchronously clear all pipeline valid bits; instr_rvalid_o = 0, instr_err_o = 0, instr_rdata_o = 32'h0.
REQ-027 SHALL hold instr_gnt_o = 0 while rst_i = 1.
REQ-028 SHALL drop all in-flight responses when reset asserts mid-operation; none emitted after release.
REQ-029 SHALL accept requests from the first rising edge after rst_i deasserts.

Configuration
REQ-030 SHALL, with macro INSTR_MEM_RESP_STALL_EN defined, include an 8-bit Fibonacci LFSR (taps 8,6,5,4), reset to 8'hA5, advancing every cycle; instr_gnt_o forced 0 in cycles where lfsr[0] = 1.
REQ-031 SHALL, without INSTR_MEM_RESP_STALL_EN, contain no LFSR and obey REQ-016 unconditionally.

Verification
REQ-032 Load 32'hDEADBEEF at 32'h0000_0010; fetch 32'h0000_0010 (LATENCY=2) -> gnt same cycle, rvalid 2 cycles later, rdata 32'hDEADBEEF, err 0.
REQ-033 Back-to-back fetches 0x0,0x4,0x8,0xC holding req 4 cycles -> 4 consecutive rvalid cycles, data in address order.
REQ-034 Fetch 32'h0000_1000 (MEM_WORDS=1024), 32'h0000_0FFC, 32'h0000_0002 -> err 1/rdata 0, err 0/valid data, err 1/rdata 0.
REQ-035 Load write and fetch same cycle to 0x20 (old 32'h11111111, new 32'h22222222) -> response 32'h11111111; next fetch -> 32'h22222222.
REQ-036 Accept two fetches, assert rst_i one cycle later -> rvalid 0 immediately and no response after release.
REQ-037 With INSTR_MEM_RESP_STALL_EN, continuous req from reset -> first-cycle gnt = 0 (lfsr[0]=1); rvalid count equals gnt count.
